branch_resolve: RTL and testbench

//   Execute-stage counterpart of the fetch-stage quick branch predictor. Compares each resolved

---
 rtl/branch_resolve.sv | 72 +++++++
 tb/tb_branch_resolve.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: checks resolved branches against fetch predictions, redirects fetch after the delay slot
// and keeps branch / mispredict statistics.
module branch_resolve #(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             ex_actual_taken,
    input  logic [31:0]      ex_actual_target,
    input  logic             ds_done,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_DS = 2'd1;
    localparam logic [1:0] REDIR   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        accept;
    logic        mismatch;
    logic        wait_ds;
    logic [31:0] correct_pc;

    // Only non-branches may pass while waiting on the delay slot; a branch there is stalled.
    assign ex_ready       = (state == IDLE) | ((state == WAIT_DS) & ~ex_is_branch);
    assign accept         = ex_valid & ex_ready & ex_is_branch & ~flush;
    assign mismatch       = (ex_pred_taken != ex_actual_taken) |
                            (ex_actual_taken & (ex_pred_target != ex_actual_target));
    assign correct_pc     = ex_actual_taken ? ex_actual_target : ex_pc + 32'd8;
    assign wait_ds        = (DELAY_SLOT != 0) & ~ds_done;
    assign redirect_valid = state == REDIR;

    always_comb begin
        state_nxt = flush                ? IDLE :
                    (state == IDLE)      ? ((accept & mismatch) ? (wait_ds ? WAIT_DS : REDIR) : IDLE) :
                    (state == WAIT_DS)   ? (ds_done ? REDIR : WAIT_DS) :
                    (state == REDIR)     ? (redirect_ready ? IDLE : REDIR) :
                    IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            redirect_pc <= 32'd0;
            mispredict  <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state      <= state_nxt;
            mispredict <= accept & mismatch;
            if (accept)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (accept & mismatch) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
                redirect_pc <= correct_pc;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scenario tasks with a redirect scoreboard; expected redirect PCs are queued
// when a mispredicting branch is accepted and popped when fetch takes the redirect.
module tb_branch_resolve;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic             ex_valid = 1'b0;
    logic             ex_ready;
    logic             ex_is_branch = 1'b0;
    logic [31:0]      ex_pc = 32'd0;
    logic             ex_pred_taken = 1'b0;
    logic [31:0]      ex_pred_target = 32'd0;
    logic             ex_actual_taken = 1'b0;
    logic [31:0]      ex_actual_target = 32'd0;
    logic             ds_done = 1'b0;
    logic             redirect_valid;
    logic             redirect_ready = 1'b0;
    logic [31:0]      redirect_pc;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [31:0]      sb_q[$];
    logic [31:0]      sb_exp;
    logic [CNT_W-1:0] exp_br = '0;
    logic [CNT_W-1:0] exp_mp = '0;

    branch_resolve #(.DELAY_SLOT(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_actual_taken(ex_actual_taken),
        .ex_actual_target(ex_actual_target), .ds_done(ds_done), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: a redirect taken by fetch must match the oldest queued correct PC.
    always @(negedge clk) begin
        if (resetn && !flush && redirect_valid && redirect_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected redirect_pc=%h, no redirect expected", redirect_pc);
            end else begin
                sb_exp = sb_q.pop_front();
                if (redirect_pc !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_redirect_pc got=%h want=%h", redirect_pc, sb_exp);
                end
            end
        end
    end

    function automatic logic mism_f(logic pt, logic [31:0] ptgt, logic at, logic [31:0] atgt);
        return (pt != at) || (at && (ptgt != atgt));
    endfunction

    function automatic logic [31:0] cpc_f(logic [31:0] pc, logic at, logic [31:0] atgt);
        return at ? atgt : pc + 32'd8;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        ex_valid = 1'b0;
        ex_is_branch = 1'b0;
        ds_done = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic at, input logic [31:0] atgt, input logic ds);
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_pc = pc;
        ex_pred_taken = pt;
        ex_pred_target = ptgt;
        ex_actual_taken = at;
        ex_actual_target = atgt;
        ds_done = ds;
    endtask

    // Drive a branch the DUT will accept and update the model accordingly.
    task automatic drive_acc(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                             input logic at, input logic [31:0] atgt, input logic ds);
        drive(pc, pt, ptgt, at, atgt, ds);
        exp_br = exp_br + 1'b1;
        if (mism_f(pt, ptgt, at, atgt)) begin
            exp_mp = exp_mp + 1'b1;
            sb_q.push_back(cpc_f(pc, at, atgt));
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({redirect_valid, mispredict, redirect_pc, branch_cnt, mispred_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b m=%b pc=%h br=%0d mp=%0d want all zero",
                     redirect_valid, mispredict, redirect_pc, branch_cnt, mispred_cnt);
        end
        n_cmp++;
        if (ex_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ex_ready got=%b want=1", ex_ready);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_correct_nt;
        drive_acc(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        idle_in();
        n_cmp++;
        if ({redirect_valid, mispredict, branch_cnt, mispred_cnt} !== {2'b00, exp_br, exp_mp} || branch_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL correct_nt got v=%b m=%b br=%0d mp=%0d want v=0 m=0 br=1 mp=0",
                     redirect_valid, mispredict, branch_cnt, mispred_cnt);
        end
        tick();
    endtask

    task automatic test_mispred_same_ds;
        redirect_ready = 1'b0;
        drive_acc(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1);
        tick();
        idle_in();
        #1;
        n_cmp++;
        if ({redirect_valid, mispredict, ex_ready, redirect_pc} !== {3'b110, 32'h2000}) begin
            n_err++;
            $display("FAIL mispred_same got v=%b m=%b rdy=%b pc=%h want v=1 m=1 rdy=0 pc=00002000",
                     redirect_valid, mispredict, ex_ready, redirect_pc);
        end
        n_cmp++;
        if ({branch_cnt, mispred_cnt} !== {4'd2, 4'd1}) begin
            n_err++;
            $display("FAIL mispred_same_cnt got br=%0d mp=%0d want br=2 mp=1", branch_cnt, mispred_cnt);
        end
        redirect_ready = 1'b1;
        tick();
        n_cmp++;
        if ({redirect_valid, mispredict} !== 2'b00) begin
            n_err++;
            $display("FAIL mispred_same_drop got v=%b m=%b want v=0 m=0", redirect_valid, mispredict);
        end
        redirect_ready = 1'b0;
    endtask

    task automatic test_wait_ds;
        drive_acc(32'h1000, 1'b1, 32'h1400, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h1004, 1'b0, 32'h0, 1'b1, 32'h9999, 1'b0);
        #1;
        n_cmp++;
        if ({ex_ready, mispredict, redirect_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL wait_ds_enter got rdy=%b m=%b v=%b want rdy=0 m=1 v=0", ex_ready, mispredict, redirect_valid);
        end
        ex_is_branch = 1'b0;
        #1;
        n_cmp++;
        if (ex_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_ds_nonbranch_ready got=%b want=1", ex_ready);
        end
        ex_is_branch = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({redirect_valid, mispredict, ex_ready} !== 3'b000) begin
                n_err++;
                $display("FAIL wait_ds_hold%0d got v=%b m=%b rdy=%b want 0 0 0", i, redirect_valid, mispredict, ex_ready);
            end
        end
        idle_in();
        ds_done = 1'b1;
        tick();
        ds_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({redirect_valid, ex_ready, redirect_pc} !== {2'b10, 32'h1008}) begin
                n_err++;
                $display("FAIL wait_ds_redir%0d got v=%b rdy=%b pc=%h want v=1 rdy=0 pc=00001008",
                         i, redirect_valid, ex_ready, redirect_pc);
            end
            tick();
        end
        redirect_ready = 1'b1;
        #1;
        tick();
        redirect_ready = 1'b0;
        n_cmp++;
        if ({redirect_valid, branch_cnt, mispred_cnt} !== {1'b0, exp_br, exp_mp}) begin
            n_err++;
            $display("FAIL wait_ds_done got v=%b br=%0d mp=%0d want v=0 br=%0d mp=%0d",
                     redirect_valid, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
    endtask

    task automatic test_jr;
        redirect_ready = 1'b1;
        drive_acc(32'h3000, 1'b1, 32'h0, 1'b1, 32'h8000_0180, 1'b1);
        tick();
        idle_in();
        n_cmp++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0180}) begin
            n_err++;
            $display("FAIL jr_redirect got v=%b pc=%h want v=1 pc=80000180", redirect_valid, redirect_pc);
        end
        tick();
        drive_acc(32'h3000, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        idle_in();
        n_cmp++;
        if ({redirect_valid, mispredict, redirect_pc} !== {2'b00, 32'h8000_0180}) begin
            n_err++;
            $display("FAIL jr_zero got v=%b m=%b pc=%h want v=0 m=0 pc=80000180", redirect_valid, mispredict, redirect_pc);
        end
        n_cmp++;
        if ({branch_cnt, mispred_cnt} !== {exp_br, exp_mp}) begin
            n_err++;
            $display("FAIL jr_cnt got br=%0d mp=%0d want br=%0d mp=%0d", branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        redirect_ready = 1'b0;
    endtask

    task automatic test_flush;
        drive_acc(32'h4000, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b1);
        tick();
        idle_in();
        n_cmp++;
        if (redirect_valid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre got v=%b want 1", redirect_valid);
        end
        redirect_ready = 1'b1;
        flush = 1'b1;
        drive(32'h4100, 1'b0, 32'h0, 1'b1, 32'h6000, 1'b1);
        tick();
        void'(sb_q.pop_front());
        n_cmp++;
        if ({redirect_valid, mispredict, branch_cnt, mispred_cnt} !== {2'b00, exp_br, exp_mp}) begin
            n_err++;
            $display("FAIL flush_redir got v=%b m=%b br=%0d mp=%0d want v=0 m=0 br=%0d mp=%0d",
                     redirect_valid, mispredict, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        tick();
        n_cmp++;
        if ({redirect_valid, mispredict, branch_cnt, mispred_cnt} !== {2'b00, exp_br, exp_mp}) begin
            n_err++;
            $display("FAIL flush_idle got v=%b m=%b br=%0d mp=%0d want v=0 m=0 br=%0d mp=%0d",
                     redirect_valid, mispredict, branch_cnt, mispred_cnt, exp_br, exp_mp);
        end
        flush = 1'b0;
        idle_in();
        redirect_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc, ptgt, atgt;
        logic        pt, at, m;
        redirect_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            atgt = $urandom & 32'hFFFF_FFFC;
            ptgt = ($urandom_range(0, 1) == 0) ? atgt : ($urandom & 32'hFFFF_FFFC);
            pt = 1'($urandom_range(0, 1));
            at = 1'($urandom_range(0, 1));
            if (i % 2 == 0) begin
                pt = 1'b0;
                at = 1'b1;
            end
            if (i == 1) begin
                pc = 32'hFFFF_FFFC;
                pt = 1'b1;
                at = 1'b0;
            end
            m = mism_f(pt, ptgt, at, atgt);
            drive_acc(pc, pt, ptgt, at, atgt, 1'b1);
            tick();
            n_cmp++;
            if ({mispredict, redirect_valid, branch_cnt, mispred_cnt} !== {m, m, exp_br, exp_mp}) begin
                n_err++;
                $display("FAIL b2b_%0d got m=%b v=%b br=%0d mp=%0d want m=%b v=%b br=%0d mp=%0d",
                         i, mispredict, redirect_valid, branch_cnt, mispred_cnt, m, m, exp_br, exp_mp);
            end
            if (m) begin
                idle_in();
                tick();
            end
        end
        idle_in();
        redirect_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_wait_ds;
        drive_acc(32'h6000, 1'b0, 32'h0, 1'b1, 32'h7000, 1'b0);
        tick();
        idle_in();
        void'(sb_q.pop_front());
        n_cmp++;
        if ({redirect_valid, mispredict} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_wait_pre got v=%b m=%b want v=0 m=1", redirect_valid, mispredict);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_br = '0;
        exp_mp = '0;
        n_cmp++;
        if ({redirect_valid, mispredict, redirect_pc, branch_cnt, mispred_cnt, ex_ready} !== {{(2 + 32 + 2 * CNT_W){1'b0}}, 1'b1}) begin
            n_err++;
            $display("FAIL rst_wait got v=%b m=%b pc=%h br=%0d mp=%0d rdy=%b want zeros rdy=1",
                     redirect_valid, mispredict, redirect_pc, branch_cnt, mispred_cnt, ex_ready);
        end
        ds_done = 1'b1;
        tick();
        ds_done = 1'b0;
        n_cmp++;
        if (redirect_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ds_ignored got v=%b want 0", redirect_valid);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 15; i++) begin
            drive_acc(32'h100 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        idle_in();
        n_cmp++;
        if (branch_cnt !== 4'hF) begin
            n_err++;
            $display("FAIL wrap_max got br=%0d want 15", branch_cnt);
        end
        drive_acc(32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
        tick();
        idle_in();
        n_cmp++;
        if ({branch_cnt, mispred_cnt} !== {exp_br, exp_mp} || branch_cnt !== 4'h0) begin
            n_err++;
            $display("FAIL wrap_zero got br=%0d mp=%0d want br=0 mp=0", branch_cnt, mispred_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_correct_nt();
        test_mispred_same_ds();
        test_wait_ds();
        test_jr();
        test_flush();
        test_back_to_back();
        test_reset_wait_ds();
        test_wrap();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got=%0d pending redirects want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
